// File: rtl/uart_cmd_assembler_pkg.sv
// Shared UART framing constants and the assembler handshake state encoding.
package uart_cmd_assembler_pkg;

  localparam int unsigned BAUD_DIV         = 2604;
  localparam int unsigned CHAR_CLKS        = 10 * BAUD_DIV;
  localparam int unsigned DEF_NUM_BYTES    = 3;
  localparam int unsigned DEF_TIMEOUT_CLKS = 2 * CHAR_CLKS;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

endpackage

// File: rtl/uart_idle_timer.sv
// Saturating inter-byte idle timer; o_expired_c is high while enabled at the terminal count.
module uart_idle_timer
  import uart_cmd_assembler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);

  localparam int unsigned TIMER_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CLKS - 1);

  logic [TIMER_W-1:0] r_timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (i_clr) begin
      r_timer <= '0;
    end else if (i_en && (r_timer != LAST)) begin
      r_timer <= r_timer + TIMER_W'(1);
    end
  end

  assign o_expired_c = i_en && (r_timer == LAST);

endmodule

// File: rtl/uart_cmd_assembler.sv
// Packs NUM_BYTES UART bytes (first byte in MSBs) into one command word with
// an rx_rdy/rx_rdy_clr byte handshake and a cmd_rdy/clr_cmd_rdy word handshake.
module uart_cmd_assembler
  import uart_cmd_assembler_pkg::*;
#(
  parameter int unsigned NUM_BYTES    = DEF_NUM_BYTES,
  parameter int unsigned TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             i_rx_byte,
  input  logic                   i_rx_rdy,
  output logic                   o_rx_rdy_clr,
  output logic [8*NUM_BYTES-1:0] o_cmd,
  output logic                   o_cmd_rdy,
  input  logic                   i_clr_cmd_rdy,
  output logic                   o_overrun,
  output logic                   o_frame_err
);

  localparam int unsigned CMD_W   = 8 * NUM_BYTES;
  localparam int unsigned SHIFT_W = 8 * (NUM_BYTES - 1);
  localparam int unsigned CNT_W   = $clog2(NUM_BYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

  state_e             r_state;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic [SHIFT_W-1:0] r_shift;
  logic [CMD_W-1:0]   r_cmd;
  logic               r_cmd_rdy;
  logic               r_rx_rdy_clr;
  logic               r_overrun;
  logic               r_frame_err;

  logic w_capture;
  logic w_last;
  logic w_timer_en;
  logic w_timer_expired;

  assign w_capture  = (r_state == ST_WAIT) && i_rx_rdy;
  assign w_last     = (r_byte_cnt == LAST_IDX);
  assign w_timer_en = (r_state == ST_WAIT) && (r_byte_cnt != '0);

  uart_idle_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_idle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_capture),
    .i_en       (w_timer_en),
    .o_expired_c(w_timer_expired)
  );

  // Handshake FSM, byte packing and output registers; capture beats timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_WAIT;
      r_byte_cnt   <= '0;
      r_shift      <= '0;
      r_cmd        <= '0;
      r_cmd_rdy    <= 1'b0;
      r_rx_rdy_clr <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      if (i_clr_cmd_rdy) begin
        r_cmd_rdy <= 1'b0;
      end
      case (r_state)
        ST_WAIT: begin
          if (i_rx_rdy) begin
            r_state      <= ST_ACK;
            r_rx_rdy_clr <= 1'b1;
            if (w_last) begin
              r_cmd      <= {r_shift, i_rx_byte};
              r_cmd_rdy  <= 1'b1;
              r_overrun  <= r_cmd_rdy && !i_clr_cmd_rdy;
              r_byte_cnt <= '0;
              r_shift    <= '0;
            end else begin
              r_shift    <= SHIFT_W'({r_shift, i_rx_byte});
              r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
          end else if (w_timer_expired) begin
            r_byte_cnt  <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b1;
          end
        end
        ST_ACK: begin
          if (!i_rx_rdy) begin
            r_state      <= ST_WAIT;
            r_rx_rdy_clr <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_WAIT;
          r_rx_rdy_clr <= 1'b0;
        end
      endcase
    end
  end

  assign o_rx_rdy_clr = r_rx_rdy_clr;
  assign o_cmd        = r_cmd;
  assign o_cmd_rdy    = r_cmd_rdy;
  assign o_overrun    = r_overrun;
  assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler: a transaction-level model of the byte and
// word handshakes is compared against the DUT every cycle, plus literal spot checks.
module tb_uart_cmd_assembler;

  localparam int unsigned NB = 3;
  localparam int unsigned TO = 52080;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_rdy = 1'b0;
  logic        clr_cmd_rdy = 1'b0;
  logic        o_rx_rdy_clr;
  logic [23:0] o_cmd;
  logic        o_cmd_rdy;
  logic        o_overrun;
  logic        o_frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  uart_cmd_assembler #(
    .NUM_BYTES   (NB),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx_byte    (rx_byte),
    .i_rx_rdy     (rx_rdy),
    .o_rx_rdy_clr (o_rx_rdy_clr),
    .o_cmd        (o_cmd),
    .o_cmd_rdy    (o_cmd_rdy),
    .i_clr_cmd_rdy(clr_cmd_rdy),
    .o_overrun    (o_overrun),
    .o_frame_err  (o_frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one byte per rx_rdy high period; every third byte forms a word; a partial
  // frame is dropped once the line has sat low TO clocks past the acknowledge.
  typedef struct packed {
    logic [23:0] frame;
    logic [1:0]  nb;
    logic [23:0] cmd;
    logic        rdy;
    logic        ovr;
    logic        ferr;
    logic        busy;
    logic [16:0] idle;
  } model_t;

  model_t m;

  function automatic model_t step(model_t s, logic rdy_in, logic [7:0] b, logic clr);
    model_t n;
    n      = s;
    n.ovr  = 1'b0;
    n.ferr = 1'b0;
    if (clr) n.rdy = 1'b0;
    if (rdy_in && !s.busy) begin
      n.frame = {s.frame[15:0], b};
      n.nb    = s.nb + 2'd1;
      n.busy  = 1'b1;
      n.idle  = '0;
      if (int'(n.nb) == NB) begin
        n.cmd   = n.frame;
        n.ovr   = s.rdy && !clr;
        n.rdy   = 1'b1;
        n.nb    = '0;
        n.frame = '0;
      end
    end else begin
      if (!rdy_in) n.busy = 1'b0;
      if (s.nb != 0 && !rdy_in) begin
        n.idle = s.idle + 17'd1;
        if (int'(n.idle) == TO + 1) begin
          n.ferr  = 1'b1;
          n.nb    = '0;
          n.frame = '0;
          n.idle  = '0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= step(m, rx_rdy, rx_byte, clr_cmd_rdy);
  end

  // Per-cycle compare plus event counters.
  int  n_clr_rise = 0;
  int  n_ovr = 0;
  int  n_ferr = 0;
  logic prev_clr = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_cmd", 32'(o_cmd), 32'(m.cmd));
      check("cyc_cmd_rdy", 32'(o_cmd_rdy), 32'(m.rdy));
      check("cyc_rx_rdy_clr", 32'(o_rx_rdy_clr), 32'(m.busy));
      check("cyc_overrun", 32'(o_overrun), 32'(m.ovr));
      check("cyc_frame_err", 32'(o_frame_err), 32'(m.ferr));
    end
    if (o_rx_rdy_clr && !prev_clr) n_clr_rise++;
    if (o_overrun) n_ovr++;
    if (o_frame_err) n_ferr++;
    prev_clr = o_rx_rdy_clr;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mimics UART_rcv: hold rx_rdy until acknowledged, then drop it.
  task automatic send(input logic [7:0] b, input bit with_clr);
    int n;
    @(negedge clk);
    rx_byte = b;
    rx_rdy  = 1'b1;
    if (with_clr) clr_cmd_rdy = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      n++;
    end while (!o_rx_rdy_clr && n < 20);
    check("ack_seen", 32'(o_rx_rdy_clr), 32'd1);
    rx_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input bit last_clr);
    send(b0, 1'b0);
    idle(2);
    send(b1, 1'b0);
    idle(2);
    send(b2, last_clr);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cmd", 32'(o_cmd), 32'h0);
    check("rst_cmd_rdy", 32'(o_cmd_rdy), 32'h0);
    check("rst_rx_rdy_clr", 32'(o_rx_rdy_clr), 32'h0);
    check("rst_overrun", 32'(o_overrun), 32'h0);
    check("rst_frame_err", 32'(o_frame_err), 32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // 1) basic frame, cmd_rdy one clock after the third rx_rdy
    send(8'hA5, 1'b0);
    idle(2);
    send(8'h3C, 1'b0);
    idle(2);
    check("t1_rdy_before", 32'(o_cmd_rdy), 32'h0);
    send(8'h0F, 1'b0);
    check("t1_cmd", 32'(o_cmd), 32'hA53C0F);
    check("t1_rdy", 32'(o_cmd_rdy), 32'h1);
    idle(3);
    check("t1_ack_pulses", 32'(n_clr_rise), 32'd3);

    // 2) clear, cmd holds, next frame
    pulse_clr();
    check("t2_rdy_cleared", 32'(o_cmd_rdy), 32'h0);
    check("t2_cmd_hold", 32'(o_cmd), 32'hA53C0F);
    send_frame(8'h00, 8'hFF, 8'h81, 1'b0);
    check("t2_cmd", 32'(o_cmd), 32'h00FF81);
    idle(3);

    // 3) overrun, then completion coinciding with clear
    pulse_clr();
    send_frame(8'h12, 8'h34, 8'h56, 1'b0);
    idle(2);
    send_frame(8'h9A, 8'hBC, 8'hDE, 1'b0);
    idle(2);
    check("t3_ovr_count", 32'(n_ovr), 32'd1);
    check("t3_cmd", 32'(o_cmd), 32'h9ABCDE);
    check("t3_rdy", 32'(o_cmd_rdy), 32'h1);
    send_frame(8'h01, 8'h02, 8'h03, 1'b1);
    idle(2);
    check("t3_sim_cmd", 32'(o_cmd), 32'h010203);
    check("t3_sim_rdy", 32'(o_cmd_rdy), 32'h1);
    check("t3_sim_no_ovr", 32'(n_ovr), 32'd1);

    // 4) partial frame timeout
    pulse_clr();
    send(8'h11, 1'b0);
    idle(2);
    send(8'h22, 1'b0);
    idle(TO + 10);
    check("t4_ferr_count", 32'(n_ferr), 32'd1);
    check("t4_rdy_untouched", 32'(o_cmd_rdy), 32'h0);
    check("t4_cmd_untouched", 32'(o_cmd), 32'h010203);
    send_frame(8'h33, 8'h44, 8'h55, 1'b0);
    check("t4_cmd", 32'(o_cmd), 32'h334455);
    idle(3);

    // 5) rx_rdy held high five clocks counts as one byte
    pulse_clr();
    @(negedge clk);
    rx_byte = 8'h66;
    rx_rdy  = 1'b1;
    idle(5);
    rx_rdy = 1'b0;
    idle(2);
    send(8'h77, 1'b0);
    idle(2);
    send(8'h88, 1'b0);
    check("t5_cmd", 32'(o_cmd), 32'h667788);
    check("t5_rdy", 32'(o_cmd_rdy), 32'h1);
    idle(3);

    // 6) reset mid-frame drops the partial byte
    send(8'h12, 1'b0);
    idle(2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_cmd", 32'(o_cmd), 32'h0);
    check("t6_rst_rdy", 32'(o_cmd_rdy), 32'h0);
    check("t6_rst_clr", 32'(o_rx_rdy_clr), 32'h0);
    check("t6_rst_ovr", 32'(o_overrun), 32'h0);
    check("t6_rst_ferr", 32'(o_frame_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send_frame(8'hDE, 8'hAD, 8'h01, 1'b0);
    check("t6_cmd", 32'(o_cmd), 32'hDEAD01);
    check("t6_rdy", 32'(o_cmd_rdy), 32'h1);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
